// File: rtl/console_bridge_pkg.sv
// Shared encodings for console_bridge: TX FSM states and the newline byte
// used by the optional line-buffered receive mode.
package console_bridge_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_e;

  localparam logic [7:0] NEWLINE = 8'h0A;

endpackage

// File: rtl/bridge_fifo.sv
// Byte FIFO with first-word-fall-through head, occupancy level 0..DEPTH and
// pointer wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
module bridge_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [7:0]             i_data,
  input  logic                   i_pop,
  output logic [7:0]             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_level == FULL_LEVEL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees the slot a same-cycle push needs when full; with no
  // bypass, a push into an empty FIFO only shows up on the next cycle.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd) begin
        r_level <= r_level + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/console_bridge.sv
// Buffered byte bridge between a UART and a host valid/ready byte stream.
// Optional line-buffered RX mode: define CONSOLE_BRIDGE_LINE_BUF_EN.
module console_bridge
  import console_bridge_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rdy,
  input  logic [7:0]                uart_dout,
  output logic                      uart_rdy_clr,
  input  logic                      uart_tx_busy,
  output logic                      uart_wr_en,
  output logic [7:0]                uart_din,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      rx_overflow,
  input  logic                      overflow_clr,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [1:0]                dbg_tx_state
);

  // Host handshakes: a byte moves exactly on a cycle where valid && ready
  // are both high at the rising edge; valid never depends on ready.

  logic       r_rdy_clr;
  logic       r_rx_push;
  logic [7:0] r_rx_byte;
  logic       r_overflow;
  logic       w_capture;
  logic       w_rx_pop;
  logic       w_rx_wr_ok;
  logic       w_rx_full;
  logic       w_rx_empty;

  assign w_capture = uart_rdy && !r_rdy_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_clr <= 1'b0;
      r_rx_push <= 1'b0;
      r_rx_byte <= '0;
    end else begin
      r_rdy_clr <= w_capture;
      r_rx_push <= w_capture;
      if (w_capture) r_rx_byte <= uart_dout;
    end
  end

  bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rx_push),
    .i_data  (r_rx_byte),
    .i_pop   (w_rx_pop),
    .o_head  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (rx_level)
  );

  assign w_rx_pop   = rx_valid && rx_ready;
  assign w_rx_wr_ok = r_rx_push && (!w_rx_full || w_rx_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (r_rx_push && !w_rx_wr_ok) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef CONSOLE_BRIDGE_LINE_BUF_EN
  logic [$clog2(RX_DEPTH):0] r_nl_count;
  logic                      w_nl_in;
  logic                      w_nl_out;

  assign w_nl_in  = w_rx_wr_ok && (r_rx_byte == NEWLINE);
  assign w_nl_out = w_rx_pop && (rx_data == NEWLINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nl_count <= '0;
    end else if (w_nl_in && !w_nl_out) begin
      r_nl_count <= r_nl_count + 1'b1;
    end else if (!w_nl_in && w_nl_out) begin
      r_nl_count <= r_nl_count - 1'b1;
    end
  end

  // Release bytes only once a full line is held, or when a full FIFO
  // would otherwise deadlock waiting for a newline.
  assign rx_valid = !w_rx_empty && ((r_nl_count != '0) || w_rx_full);
`else
  assign rx_valid = !w_rx_empty;
`endif

  tx_state_e  r_state;
  tx_state_e  w_next;
  logic       w_tx_pop;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       r_wr_en;
  logic [7:0] r_uart_din;

  assign tx_ready = !w_tx_full;

  bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (tx_valid && tx_ready),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_tx_empty && !uart_tx_busy) begin
          w_tx_pop = 1'b1;
          w_next   = TX_START;
        end
      end
      TX_START: if (uart_tx_busy) w_next = TX_BUSY;
      TX_BUSY:  if (!uart_tx_busy) w_next = TX_IDLE;
      default:  w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TX_IDLE;
      r_wr_en    <= 1'b0;
      r_uart_din <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= (w_next == TX_START);
      if (w_tx_pop) r_uart_din <= w_tx_head;
    end
  end

  assign uart_rdy_clr = r_rdy_clr;
  assign uart_wr_en   = r_wr_en;
  assign uart_din     = r_uart_din;
  assign rx_overflow  = r_overflow;
  assign dbg_tx_state = r_state;

endmodule

// File: tb/tb_console_bridge.sv
// Directed self-checking bench for console_bridge with a behavioural UART
// transmitter (10-cycle busy per byte) and a TX byte scoreboard.
module tb_console_bridge;

  localparam int RX_DEPTH = 4;
  localparam int TX_DEPTH = 4;
`ifdef CONSOLE_BRIDGE_LINE_BUF_EN
  localparam logic [7:0] T1_BYTE = 8'h0A;
`else
  localparam logic [7:0] T1_BYTE = 8'h41;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rdy;
  logic [7:0] uart_dout;
  logic       uart_rdy_clr;
  logic       uart_tx_busy;
  logic       uart_wr_en;
  logic [7:0] uart_din;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_overflow;
  logic       overflow_clr;
  logic [2:0] rx_level;
  logic [2:0] tx_level;
  logic [1:0] dbg_tx_state;

  logic       model_busy;
  logic       force_busy;
  int         busy_cnt;
  int         episodes;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  assign uart_tx_busy = model_busy | force_busy;

  console_bridge #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rdy     (uart_rdy),
    .uart_dout    (uart_dout),
    .uart_rdy_clr (uart_rdy_clr),
    .uart_tx_busy (uart_tx_busy),
    .uart_wr_en   (uart_wr_en),
    .uart_din     (uart_din),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_overflow  (rx_overflow),
    .overflow_clr (overflow_clr),
    .rx_level     (rx_level),
    .tx_level     (tx_level),
    .dbg_tx_state (dbg_tx_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model and TX scoreboard
  initial begin
    logic [7:0] e;
    model_busy = 1'b0;
    busy_cnt   = 0;
    episodes   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_busy = 1'b0;
        busy_cnt   = 0;
      end else if (model_busy) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end else if (uart_wr_en) begin
        episodes++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check("tx_din", uart_din, e);
        model_busy = 1'b1;
        busy_cnt   = 10;
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic do_reset();
    rst_n = 1'b0; uart_rdy = 1'b0; uart_dout = '0; rx_ready = 1'b0;
    tx_data = '0; tx_valid = 1'b0; overflow_clr = 1'b0; force_busy = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic got;
    got = 1'b0;
    uart_rdy = 1'b1;
    uart_dout = b;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (uart_rdy_clr) got = 1'b1;
    end
    uart_rdy = 1'b0;
    check("rx_handshake", got, 1);
  endtask

  task automatic pop_rx(input logic [7:0] b);
    check("rx_valid_before_pop", rx_valid, 1);
    check("rx_data", rx_data, b);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    logic done;
    done = 1'b0;
    exp_q.push_back(b);
    tx_valid = 1'b1;
    tx_data = b;
    for (int i = 0; i < 100 && !done; i++) begin
      if (tx_ready) done = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("tx_push_accepted", done, 1);
  endtask

  task automatic wait_tx_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !model_busy && dbg_tx_state == 2'd0 && tx_level == 3'd0)
        done = 1'b1;
    end
    check("tx_drain", done, 1);
  endtask

  // directed sequence
  initial begin
    int ep0;
    logic seen;
    do_reset();

    // reset values
    check("rst_rdy_clr", uart_rdy_clr, 0);
    check("rst_wr_en", uart_wr_en, 0);
    check("rst_din", uart_din, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_overflow", rx_overflow, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_state", dbg_tx_state, 0);

    // RX capture: rdy held two cycles, one push, clr pulse of width 1
    uart_rdy = 1'b1; uart_dout = T1_BYTE;
    @(negedge clk);
    check("rx1_clr_high", uart_rdy_clr, 1);
    check("rx1_valid_early", rx_valid, 0);
    @(negedge clk);
    check("rx1_clr_low", uart_rdy_clr, 0);
    check("rx1_valid", rx_valid, 1);
    check("rx1_data", rx_data, T1_BYTE);
    uart_rdy = 1'b0;
    @(negedge clk);
    check("rx1_single_push", rx_level, 1);
    pop_rx(T1_BYTE);
    check("rx1_empty", rx_valid, 0);

    // TX: two bytes, 2-cycle push-to-wr_en latency
    ep0 = episodes;
    push_tx(8'h48);
    check("tx_lvl_after_push", tx_level, 1);
    check("tx_wr_en_not_yet", uart_wr_en, 0);
    push_tx(8'h69);
    check("tx_wr_en_latency", uart_wr_en, 1);
    check("tx_din_first", uart_din, 8'h48);
    check("tx_lvl_push_pop", tx_level, 1);
    wait_tx_drain();
    check("tx_episodes_2", episodes - ep0, 2);
    check("tx_din_last", uart_din, 8'h69);
    check("tx_lvl_zero", tx_level, 0);

    // RX overflow: RX_DEPTH+1 bytes with host stalled
    send_rx(8'h10); send_rx(8'h11); send_rx(8'h12); send_rx(8'h0A); send_rx(8'h14);
    @(negedge clk);
    check("ovf_level", rx_level, RX_DEPTH);
    check("ovf_flag", rx_overflow, 1);
    pop_rx(8'h10); pop_rx(8'h11); pop_rx(8'h12); pop_rx(8'h0A);
    check("ovf_drained", rx_level, 0);
    check("ovf_sticky", rx_overflow, 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_cleared", rx_overflow, 0);

    // TX full, FSM pop and host refill across the pointer wrap
    ep0 = episodes;
    force_busy = 1'b1;
    push_tx(8'hA0); push_tx(8'hA1); push_tx(8'hA2); push_tx(8'hA3);
    check("txf_level_full", tx_level, TX_DEPTH);
    check("txf_ready_low", tx_ready, 0);
    force_busy = 1'b0;
    exp_q.push_back(8'hA4);
    tx_valid = 1'b1; tx_data = 8'hA4;
    @(negedge clk);
    check("txf_level_popped", tx_level, 3);
    check("txf_ready_back", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("txf_level_refill", tx_level, TX_DEPTH);
    wait_tx_drain();
    check("txf_episodes_5", episodes - ep0, 5);
    check("txf_din_last", uart_din, 8'hA4);

    // reset during BUSY abandons in-flight byte and empties both FIFOs
    send_rx(8'h0A);
    @(negedge clk);
    check("rrst_rx_level_pre", rx_level, 1);
    push_tx(8'h55); push_tx(8'h66);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dbg_tx_state == 2'd2) seen = 1'b1;
    end
    check("rrst_reached_busy", seen, 1);
    rst_n = 1'b0;
    #1;
    check("rrst_wr_en", uart_wr_en, 0);
    check("rrst_din", uart_din, 8'h00);
    check("rrst_state", dbg_tx_state, 0);
    check("rrst_tx_level", tx_level, 0);
    check("rrst_rx_level", rx_level, 0);
    check("rrst_rx_valid", rx_valid, 0);
    check("rrst_tx_ready", tx_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ep0 = episodes;
    push_tx(8'h77);
    wait_tx_drain();
    check("rrst_episodes_1", episodes - ep0, 1);
    check("rrst_din_fresh", uart_din, 8'h77);

`ifdef CONSOLE_BRIDGE_LINE_BUF_EN
    // line buffering: hold bytes until a newline is stored
    send_rx(8'h61);
    @(negedge clk);
    check("lb_hold_a", rx_valid, 0);
    send_rx(8'h62);
    @(negedge clk);
    check("lb_hold_b", rx_valid, 0);
    send_rx(8'h0A);
    check("lb_hold_nl_inflight", rx_valid, 0);
    @(negedge clk);
    check("lb_level_3", rx_level, 3);
    pop_rx(8'h61); pop_rx(8'h62); pop_rx(8'h0A);
    check("lb_drained", rx_valid, 0);
    // full FIFO without newline releases
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    @(negedge clk);
    check("lb_full_valid", rx_valid, 1);
    pop_rx(8'h01);
    check("lb_not_full_hold", rx_valid, 0);
    send_rx(8'h0A);
    @(negedge clk);
    pop_rx(8'h02); pop_rx(8'h03); pop_rx(8'h04); pop_rx(8'h0A);
    check("lb_nl_count_zero", rx_valid, 0);
    check("lb_level_zero", rx_level, 0);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
